// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the seq_divider block.
// DIV_MAX_W bounds the operand width the helper function can handle (WIDTH < DIV_MAX_W).
package div_pkg;

    localparam int DIV_MAX_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

    // Conditional two's-complement negate; callers zero-extend and slice back to WIDTH.
    // The low WIDTH bits of the result equal the WIDTH-bit negate, so one helper
    // serves both abs() of operands and sign fix-up of results.
    function automatic logic [DIV_MAX_W-1:0] cond_neg(input logic [DIV_MAX_W-1:0] v,
                                                      input logic                 neg);
        return neg ? (~v + DIV_MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: operand/result handshake bundle for seq_divider.
// remainder exists only when DIV_REM_EN is defined.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
`ifdef DIV_REM_EN
    logic [WIDTH-1:0] remainder;
`endif
    logic             div_zero;
    logic             ovf;

    modport master (
        output in_valid, in_signed, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient,
`ifdef DIV_REM_EN
        input  remainder,
`endif
        input  div_zero, ovf
    );

    modport slave (
        input  in_valid, in_signed, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient,
`ifdef DIV_REM_EN
        output remainder,
`endif
        output div_zero, ovf
    );
endinterface

// File: rtl/div_addsub_stage.sv
// div_addsub_stage: one non-restoring step on a (WIDTH+1)-bit partial remainder.
// Adds the divisor when the partial remainder is negative, subtracts otherwise.
module div_addsub_stage #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   p_in,
    input  logic [WIDTH-1:0] d_in,
    input  logic             p_neg,
    output logic [WIDTH:0]   p_out
);
    logic [WIDTH:0] d_ext;

    assign d_ext = {1'b0, d_in};
    assign p_out = p_neg ? (p_in + d_ext) : (p_in - d_ext);

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multicycle non-restoring integer divider, signed or unsigned per operation.
// Define DIV_REM_EN to get the remainder output and its correction adder path.
// WIDTH must be in 4..DIV_MAX_W-1.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | one quotient bit per cycle, WIDTH cycles
// FIX   | remainder correction and result sign fix-up
// DONE  | result held on outputs until out_ready
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t           state, state_nxt;
    logic                 accept;
    logic [WIDTH:0]       p_reg;
    logic [WIDTH-1:0]     q_reg;
    logic [WIDTH-1:0]     d_reg;
    logic [CNT_W-1:0]     cnt;
    logic                 q_neg;
    logic                 ovf_pend;
    logic [WIDTH-1:0]     quot_res;
    logic                 dz_res;
    logic                 ovf_res;
    logic                 dvd_neg, dvs_neg;
    logic                 div_is_zero, is_min_m1;
    logic [DIV_MAX_W-1:0] dvd_x, dvs_x, quot_x;
    logic [WIDTH:0]       stage_p, stage_sum;
    logic                 stage_neg;
    logic                 unused_hi;
`ifdef DIV_REM_EN
    logic                 r_neg;
    logic [WIDTH-1:0]     rem_res;
    logic [WIDTH-1:0]     rem_corr;
    logic [DIV_MAX_W-1:0] rem_x;
    logic                 unused_rem;
`endif

    assign dvd_neg     = bus.in_signed & bus.dividend[WIDTH-1];
    assign dvs_neg     = bus.in_signed & bus.divisor[WIDTH-1];
    assign div_is_zero = (bus.divisor == '0);
    assign is_min_m1   = bus.in_signed && (bus.dividend == MIN_VAL) && (bus.divisor == '1);

    assign dvd_x  = cond_neg(DIV_MAX_W'(bus.dividend), dvd_neg);
    assign dvs_x  = cond_neg(DIV_MAX_W'(bus.divisor), dvs_neg);
    assign quot_x = cond_neg(DIV_MAX_W'(q_reg), q_neg);
    assign unused_hi = ^{dvd_x[DIV_MAX_W-1:WIDTH], dvs_x[DIV_MAX_W-1:WIDTH],
                         quot_x[DIV_MAX_W-1:WIDTH]};

`ifdef DIV_REM_EN
    // In FIX the shared stage is forced to add, giving P+D for the negative-remainder case.
    assign stage_p    = (state == CALC) ? {p_reg[WIDTH-1:0], q_reg[WIDTH-1]} : p_reg;
    assign stage_neg  = (state == CALC) ? p_reg[WIDTH] : 1'b1;
    assign rem_corr   = p_reg[WIDTH] ? stage_sum[WIDTH-1:0] : p_reg[WIDTH-1:0];
    assign rem_x      = cond_neg(DIV_MAX_W'(rem_corr), r_neg);
    assign unused_rem = ^rem_x[DIV_MAX_W-1:WIDTH];
    assign bus.remainder = rem_res;
`else
    assign stage_p   = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign stage_neg = p_reg[WIDTH];
`endif

    div_addsub_stage #(.WIDTH(WIDTH)) u_stage (
        .p_in  (stage_p),
        .d_in  (d_reg),
        .p_neg (stage_neg),
        .p_out (stage_sum)
    );

    assign bus.quotient = quot_res;
    assign bus.div_zero = dz_res;
    assign bus.ovf      = ovf_res;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = div_is_zero ? DONE : CALC;
                end
            end
            CALC: if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg    <= '0;
            q_reg    <= '0;
            d_reg    <= '0;
            cnt      <= '0;
            q_neg    <= 1'b0;
            ovf_pend <= 1'b0;
            quot_res <= '0;
            dz_res   <= 1'b0;
            ovf_res  <= 1'b0;
`ifdef DIV_REM_EN
            r_neg    <= 1'b0;
            rem_res  <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    p_reg    <= '0;
                    q_reg    <= dvd_x[WIDTH-1:0];
                    d_reg    <= dvs_x[WIDTH-1:0];
                    cnt      <= CNT_INIT;
                    q_neg    <= dvd_neg ^ dvs_neg;
                    ovf_pend <= is_min_m1;
`ifdef DIV_REM_EN
                    r_neg    <= dvd_neg;
`endif
                    // Zero divisor bypasses CALC/FIX, so its result is loaded here.
                    if (div_is_zero) begin
                        quot_res <= '1;
                        dz_res   <= 1'b1;
                        ovf_res  <= 1'b0;
`ifdef DIV_REM_EN
                        rem_res  <= bus.dividend;
`endif
                    end
                end
                CALC: begin
                    p_reg <= stage_sum;
                    q_reg <= {q_reg[WIDTH-2:0], ~stage_sum[WIDTH]};
                    cnt   <= cnt - CNT_W'(1);
                end
                FIX: begin
                    dz_res  <= 1'b0;
                    ovf_res <= ovf_pend;
                    if (ovf_pend) begin
                        quot_res <= MIN_VAL;
`ifdef DIV_REM_EN
                        rem_res  <= '0;
`endif
                    end else begin
                        quot_res <= quot_x[WIDTH-1:0];
`ifdef DIV_REM_EN
                        rem_res  <= rem_x[WIDTH-1:0];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider at WIDTH=32 and WIDTH=8.
// Remainder checks are compiled in when DIV_REM_EN is defined.
module tb_seq_divider;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        dz;
        logic        ovf;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   rdy_mode = 0;
    exp_t q32[$];
    exp_t q8[$];
    exp_t e32, e8;
    bit   rose32 = 1'b0, taken32 = 1'b0;
    bit   rose8 = 1'b0, taken8 = 1'b0;

    seq_divider_if #(.WIDTH(32)) b32();
    seq_divider_if #(.WIDTH(8))  b8();

    seq_divider #(.WIDTH(32)) u_div32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    seq_divider #(.WIDTH(8))  u_div8  (.clk(clk), .rst_n(rst_n), .bus(b8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic with the divider's special-case rules.
    function automatic exp_t model(int w, bit sgn, logic [63:0] a, logic [63:0] b);
        exp_t        e;
        logic [63:0] mask, minv;
        longint      sa, sb, t;
        mask  = (64'd1 << w) - 64'd1;
        minv  = 64'd1 << (w - 1);
        e.q   = '0;
        e.r   = '0;
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        e.lat = w + 2;
        e.acc = 0;
        if (b == 64'd0) begin
            e.q = mask; e.r = a; e.dz = 1'b1; e.lat = 1;
        end else if (sgn) begin
            sa = longint'(a) - (a[w-1] ? longint'(mask) + 1 : 0);
            sb = longint'(b) - (b[w-1] ? longint'(mask) + 1 : 0);
            if (a == minv && b == mask) begin
                e.q = minv; e.r = '0; e.ovf = 1'b1;
            end else begin
                t = sa / sb; e.q = t & mask;
                t = sa % sb; e.r = t & mask;
            end
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    function automatic logic [63:0] pick(int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return mask;
            3: return 64'd1 << (w - 1);
            4: return 64'($urandom_range(0, 15));
            default: return {32'd0, $urandom} & mask;
        endcase
    endfunction

    task automatic issue32(bit sgn, logic [31:0] a, logic [31:0] b);
        exp_t e;
        int   n = 0;
        bit   ok = 1'b0;
        @(negedge clk);
        b32.in_valid = 1'b1; b32.in_signed = sgn; b32.dividend = a; b32.divisor = b;
        while (!ok && n < 300) begin
            ok = b32.in_ready;
            @(posedge clk); #1;
            if (!ok) begin @(negedge clk); n++; end
        end
        cmp("accept32", 64'(ok), 64'd1);
        e = model(32, sgn, 64'(a), 64'(b));
        e.acc = cyc;
        if (ok) q32.push_back(e);
        b32.in_valid = 1'b0;
    endtask

    task automatic issue8(bit sgn, logic [7:0] a, logic [7:0] b);
        exp_t e;
        int   n = 0;
        bit   ok = 1'b0;
        @(negedge clk);
        b8.in_valid = 1'b1; b8.in_signed = sgn; b8.dividend = a; b8.divisor = b;
        while (!ok && n < 300) begin
            ok = b8.in_ready;
            @(posedge clk); #1;
            if (!ok) begin @(negedge clk); n++; end
        end
        cmp("accept8", 64'(ok), 64'd1);
        e = model(8, sgn, 64'(a), 64'(b));
        e.acc = cyc;
        if (ok) q8.push_back(e);
        b8.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 3000) begin
            @(negedge clk); n++;
        end
        cmp("drain", 64'(q32.size() + q8.size()), 64'd0);
    endtask

    // Monitor for the 32-bit divider: drives out_ready, compares against the queue head.
    always @(negedge clk) begin
        if (!rst_n) begin
            rose32 = 1'b0; taken32 = 1'b0;
        end else begin
            case (rdy_mode)
                0:       b32.out_ready = 1'b1;
                1:       b32.out_ready = 1'($urandom_range(0, 1));
                default: b32.out_ready = 1'b0;
            endcase
            if (taken32) begin
                cmp("idle_after_take32", 64'({b32.in_ready, b32.out_valid}), 64'b10);
                taken32 = 1'b0;
            end
            if (b32.out_valid) begin
                if (q32.size() == 0) begin
                    cmp("unexpected_valid32", 64'(b32.out_valid), 64'd0);
                end else begin
                    e32 = q32[0];
                    if (!rose32) begin
                        cmp("latency32", 64'(cyc - e32.acc + 1), 64'(e32.lat));
                        rose32 = 1'b1;
                    end
                    cmp("quotient32", 64'(b32.quotient), e32.q);
`ifdef DIV_REM_EN
                    cmp("remainder32", 64'(b32.remainder), e32.r);
`endif
                    cmp("div_zero32", 64'(b32.div_zero), 64'(e32.dz));
                    cmp("ovf32", 64'(b32.ovf), 64'(e32.ovf));
                    cmp("busy_in_ready32", 64'(b32.in_ready), 64'd0);
                    if (b32.out_ready) begin
                        q32.delete(0); rose32 = 1'b0; taken32 = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor for the 8-bit divider, always with random back-pressure.
    always @(negedge clk) begin
        if (!rst_n) begin
            rose8 = 1'b0; taken8 = 1'b0;
        end else begin
            b8.out_ready = 1'($urandom_range(0, 1));
            if (taken8) begin
                cmp("idle_after_take8", 64'({b8.in_ready, b8.out_valid}), 64'b10);
                taken8 = 1'b0;
            end
            if (b8.out_valid) begin
                if (q8.size() == 0) begin
                    cmp("unexpected_valid8", 64'(b8.out_valid), 64'd0);
                end else begin
                    e8 = q8[0];
                    if (!rose8) begin
                        cmp("latency8", 64'(cyc - e8.acc + 1), 64'(e8.lat));
                        rose8 = 1'b1;
                    end
                    cmp("quotient8", 64'(b8.quotient), e8.q);
`ifdef DIV_REM_EN
                    cmp("remainder8", 64'(b8.remainder), e8.r);
`endif
                    cmp("div_zero8", 64'(b8.div_zero), 64'(e8.dz));
                    cmp("ovf8", 64'(b8.ovf), 64'(e8.ovf));
                    if (b8.out_ready) begin
                        q8.delete(0); rose8 = 1'b0; taken8 = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [63:0] a, b;
        rst_n = 1'b0;
        b32.in_valid = 1'b0; b32.in_signed = 1'b0; b32.dividend = '0; b32.divisor = '0;
        b8.in_valid  = 1'b0; b8.in_signed  = 1'b0; b8.dividend  = '0; b8.divisor  = '0;
        repeat (3) @(negedge clk);
        cmp("rst_in_ready32", 64'(b32.in_ready), 64'd1);
        cmp("rst_out_valid32", 64'(b32.out_valid), 64'd0);
        cmp("rst_quotient32", 64'(b32.quotient), 64'd0);
        cmp("rst_flags32", 64'({b32.div_zero, b32.ovf}), 64'd0);
`ifdef DIV_REM_EN
        cmp("rst_remainder32", 64'(b32.remainder), 64'd0);
`endif
        cmp("rst_in_ready8", 64'(b8.in_ready), 64'd1);
        cmp("rst_out_valid8", 64'(b8.out_valid), 64'd0);
        rst_n = 1'b1;

        // Directed cases, including the boundary conditions.
        rdy_mode = 0;
        issue32(1'b0, 32'd7, 32'd2);
        issue32(1'b1, 32'hFFFF_FFF9, 32'd2);
        issue32(1'b1, 32'd7, 32'hFFFF_FFFE);
        issue32(1'b0, 32'd5, 32'd0);
        issue32(1'b1, 32'hFFFF_FFFB, 32'd0);
        issue32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        issue32(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        issue32(1'b1, 32'd0, 32'd5);
        issue32(1'b0, 32'hFFFF_FFFF, 32'd1);
        issue32(1'b0, 32'd1000, 32'd3);
        // Operands offered while busy must be ignored, not queued.
        @(negedge clk);
        b32.in_valid = 1'b1; b32.dividend = 32'd9; b32.divisor = 32'd9;
        repeat (5) @(negedge clk);
        b32.in_valid = 1'b0;
        drain();

        // Hold the result for several cycles with out_ready low.
        rdy_mode = 2;
        issue32(1'b0, 32'd100, 32'd7);
        n = 0;
        while (!b32.out_valid && n < 100) begin @(negedge clk); n++; end
        cmp("stall_reach_done", 64'(b32.out_valid), 64'd1);
        repeat (5) @(negedge clk);
        rdy_mode = 0;
        drain();

        // Random 32-bit traffic with random back-pressure.
        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            a = pick(32); b = pick(32);
            issue32(1'($urandom_range(0, 1)), a[31:0], b[31:0]);
        end
        drain();

        // Reset in the middle of CALC aborts with no result.
        rdy_mode = 0;
        issue32(1'b0, 32'd12345, 32'd67);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("abort_in_ready", 64'(b32.in_ready), 64'd1);
        cmp("abort_out_valid", 64'(b32.out_valid), 64'd0);
        q32.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cmp("no_partial_result", 64'(b32.out_valid), 64'd0);
        end
        issue32(1'b0, 32'd7, 32'd2);
        drain();

        // Random 8-bit traffic: corner operands are frequent at this width.
        for (int i = 0; i < 300; i++) begin
            a = pick(8); b = pick(8);
            issue8(1'($urandom_range(0, 1)), a[7:0], b[7:0]);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
